// File: rtl/mul_pkg.sv
// Shared constants for the shift-add multiplier: ALU opcode and default operand width.
// Pure declarations; no logic, no latency.
package mul_pkg;
    localparam int          DEFAULT_WIDTH = 32;
    localparam logic [5:0]  ADDU_OP       = 6'b001001;
endpackage

// File: rtl/multiplier_datapath_if.sv
// Command/result bundle between the multiplier controller (master) and datapath (slave).
// Plain wires; the datapath answers one clock after each command, no stall path.
interface multiplier_datapath_if
    import mul_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
);
    logic [WIDTH-1:0]   Multiplicand;
    logic [WIDTH-1:0]   Multiplier;
    logic               W_ctrl;
    logic [5:0]         ADDU_ctrl;
    logic               SRL_ctrl;
    logic               Ready;
    logic               LSB;
    logic [2*WIDTH-1:0] Product;

    modport master (
        output Multiplicand, Multiplier, W_ctrl, ADDU_ctrl, SRL_ctrl, Ready,
        input  LSB, Product
    );

    modport slave (
        input  Multiplicand, Multiplier, W_ctrl, ADDU_ctrl, SRL_ctrl, Ready,
        output LSB, Product
    );
endinterface

// File: rtl/multiplier_datapath_alu_addu.sv
// Unsigned WIDTH-bit adder with carry-out; any opcode other than ADDU passes i_a through.
// Purely combinational, no backpressure.
module alu_addu
    import mul_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic [5:0]       i_op,
    output logic [WIDTH-1:0] o_sum,
    output logic             o_carry
);
    logic [WIDTH:0] w_result;

    always_comb begin
        w_result = {1'b0, i_a};
        if (i_op == ADDU_OP) begin
            w_result = {1'b0, i_a} + {1'b0, i_b};
        end
    end

    assign o_sum   = w_result[WIDTH-1:0];
    assign o_carry = w_result[WIDTH];
endmodule

// File: rtl/multiplier_datapath.sv
// Shift-add multiplier datapath: multiplicand, {carry, upper, lower} product register, fused add+shift.
// Outputs are registered (one edge after each command); Ready freezes all state, Reset always wins.
module multiplier_datapath
    import mul_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic                  clk,
    input  logic                  Reset,
    multiplier_datapath_if.slave  bus
);
    logic [WIDTH-1:0]   r_mcand;
    logic [2*WIDTH-1:0] r_prod;
    logic               r_carry;

    logic [WIDTH-1:0]   w_mcand_nxt;
    logic [2*WIDTH-1:0] w_prod_nxt;
    logic               w_carry_nxt;

    logic [WIDTH-1:0]   w_alu_sum;
    logic               w_alu_carry;

    alu_addu #(
        .WIDTH (WIDTH)
    ) u_alu (
        .i_a     (r_prod[2*WIDTH-1:WIDTH]),
        .i_b     (r_mcand),
        .i_op    (bus.ADDU_ctrl),
        .o_sum   (w_alu_sum),
        .o_carry (w_alu_carry)
    );

    always_comb begin
        w_mcand_nxt = r_mcand;
        w_prod_nxt  = r_prod;
        w_carry_nxt = r_carry;
        if (Reset) begin
            w_mcand_nxt = bus.Multiplicand;
            w_prod_nxt  = {{WIDTH{1'b0}}, bus.Multiplier};
            w_carry_nxt = 1'b0;
        end else if (!bus.Ready) begin
            unique case ({bus.W_ctrl, bus.SRL_ctrl})
                2'b10: begin
                    w_prod_nxt  = {w_alu_sum, r_prod[WIDTH-1:0]};
                    w_carry_nxt = w_alu_carry;
                end
                2'b01: begin
                    w_prod_nxt  = {r_carry, r_prod[2*WIDTH-1:1]};
                    w_carry_nxt = 1'b0;
                end
                // Fused iteration: the add's carry-out lands in the upper MSB directly.
                2'b11: begin
                    w_prod_nxt  = {w_alu_carry, w_alu_sum, r_prod[WIDTH-1:1]};
                    w_carry_nxt = 1'b0;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        r_mcand <= w_mcand_nxt;
        r_prod  <= w_prod_nxt;
        r_carry <= w_carry_nxt;
    end

    assign bus.LSB     = r_prod[0];
    assign bus.Product = r_prod;
endmodule

// File: tb/tb_multiplier_datapath.sv
// Scoreboard bench: stimulus queues expected {Product, LSB}; a negedge monitor pops and compares.
module tb_multiplier_datapath;
    import mul_pkg::*;

    localparam int W = 32;

    logic clk;
    logic Reset;
    multiplier_datapath_if #(.WIDTH(W)) bus ();

    multiplier_datapath #(.WIDTH(W)) dut (
        .clk   (clk),
        .Reset (Reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    string             name_q[$];
    logic [2*W-1:0]    prod_q[$];
    logic              lsb_q[$];
    int                checks = 0;
    int                errors = 0;

    always @(negedge clk) begin
        while (prod_q.size() > 0) begin
            string          n;
            logic [2*W-1:0] p;
            logic           l;
            n = name_q.pop_front();
            p = prod_q.pop_front();
            l = lsb_q.pop_front();
            checks++;
            if (bus.Product !== p || bus.LSB !== l) begin
                errors++;
                $display("FAIL %s: Product=%h LSB=%b, expected Product=%h LSB=%b",
                         n, bus.Product, bus.LSB, p, l);
            end
        end
    end

    task automatic expect_out(input string n, input logic [2*W-1:0] p, input logic l);
        name_q.push_back(n);
        prod_q.push_back(p);
        lsb_q.push_back(l);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_cmds();
        bus.W_ctrl    = 1'b0;
        bus.SRL_ctrl  = 1'b0;
        bus.ADDU_ctrl = 6'b000000;
    endtask

    task automatic load(input logic [W-1:0] a, input logic [W-1:0] b);
        Reset            = 1'b1;
        bus.Multiplicand = a;
        bus.Multiplier   = b;
        step();
        Reset = 1'b0;
        idle_cmds();
    endtask

    // Plays the controller: W follows LSB, ADDU selected, shift every cycle.
    task automatic iterate(input int n, input bool_zero_chk);
        for (int i = 0; i < n; i++) begin
            bus.W_ctrl    = bus.LSB;
            bus.ADDU_ctrl = ADDU_OP;
            bus.SRL_ctrl  = 1'b1;
            step();
            if (bool_zero_chk) expect_out("zero_iter", '0, 1'b0);
        end
        idle_cmds();
    endtask

    initial begin
        Reset            = 1'b1;
        bus.Multiplicand = '0;
        bus.Multiplier   = '0;
        bus.Ready        = 1'b0;
        idle_cmds();

        // 3 x 5, with operands scrambled after load
        load(32'd3, 32'd5);
        expect_out("reset_state", 64'd5, 1'b1);
        bus.Multiplicand = 32'hDEADBEEF;
        bus.Multiplier   = 32'hCAFEF00D;
        iterate(W, 1'b0);
        expect_out("mul_3x5", 64'd15, 1'b1);
        bus.Ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            bus.W_ctrl    = i[0];
            bus.SRL_ctrl  = 1'b1;
            bus.ADDU_ctrl = i[1] ? ADDU_OP : 6'b000000;
            step();
            expect_out("ready_hold", 64'd15, 1'b1);
        end
        bus.Ready = 1'b0;
        idle_cmds();

        // all-ones operands
        load(32'hFFFFFFFF, 32'hFFFFFFFF);
        expect_out("reset_ones", 64'h00000000_FFFFFFFF, 1'b1);
        iterate(W, 1'b0);
        expect_out("mul_ones", 64'hFFFFFFFE_00000001, 1'b1);

        // zero multiplier, then zero multiplicand
        load(32'h12345678, 32'd0);
        expect_out("reset_b0", 64'd0, 1'b0);
        iterate(W, 1'b1);
        load(32'd0, 32'hFFFFFFFF);
        iterate(W, 1'b0);
        expect_out("mul_a0", 64'd0, 1'b0);

        // individual commands
        load(32'd7, 32'd1);
        bus.W_ctrl = 1'b1; bus.ADDU_ctrl = 6'b000000; bus.SRL_ctrl = 1'b0;
        step();
        expect_out("write_pass", 64'h00000000_00000001, 1'b1);
        bus.ADDU_ctrl = ADDU_OP;
        step();
        expect_out("write_add", 64'h00000007_00000001, 1'b1);
        idle_cmds();
        step();
        expect_out("hold_cmd", 64'h00000007_00000001, 1'b1);
        bus.SRL_ctrl = 1'b1;
        step();
        expect_out("shift_only", 64'h00000003_80000000, 1'b0);
        idle_cmds();

        // reset mid-multiply
        load(32'd9, 32'd11);
        iterate(10, 1'b0);
        load(32'd2, 32'd4);
        expect_out("mid_reset", 64'd4, 1'b0);
        iterate(W, 1'b0);
        expect_out("mul_2x4", 64'd8, 1'b0);

        // Ready freeze then Reset overriding Ready
        bus.Ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            bus.W_ctrl    = 1'b1;
            bus.SRL_ctrl  = 1'b1;
            bus.ADDU_ctrl = i[0] ? ADDU_OP : 6'b000000;
            step();
            expect_out("ready_freeze", 64'd8, 1'b0);
        end
        load(32'd5, 32'd6);
        expect_out("reset_over_ready", 64'd6, 1'b0);
        bus.Ready = 1'b0;
        iterate(W, 1'b0);
        expect_out("mul_5x6", 64'd30, 1'b0);

        repeat (3) @(negedge clk);
        checks++;
        if (prod_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", prod_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
